window_3x3_gen: RTL and testbench

- Producer side of the sharpening datapath's 3x3 window interface.
- Accepts a raster-order pixel stream, one pixel per valid cycle.
- Buffers the two previous image lines and emits each complete interior 3x3 neighbourhood as nine parallel pixels plus a one-cycle done strobe.
- Feeds the kernel/arithmetic stage directly: win_0..win_8 drive data_in_0..data_in_8, win_done drives data_in_done.

---
 rtl/sharpen_pkg.sv | 24 ++
 rtl/line_buffer.sv | 31 +++
 rtl/window_3x3_gen.sv | 182 ++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sharpen_pkg.sv
// sharpen_pkg
// Shared definitions for the sharpening datapath: window generator state
// encoding and the 3x3 tap numbering used by both the window producer and
// the kernel stage. Taps are row-major, 0 = top-left, 8 = bottom-right.
package sharpen_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_ACTIVE = 2'd2
  } win_state_t;

  localparam int WIN_TAPS   = 9;
  localparam int TAP_TL     = 0;
  localparam int TAP_TC     = 1;
  localparam int TAP_TR     = 2;
  localparam int TAP_ML     = 3;
  localparam int TAP_CENTRE = 4;
  localparam int TAP_MR     = 5;
  localparam int TAP_BL     = 6;
  localparam int TAP_BC     = 7;
  localparam int TAP_BR     = 8;

endpackage

// File: rtl/line_buffer.sv
// line_buffer
// Single-port line store, read-before-write. The read data for the current
// address is available in the same cycle as the address, and a write at
// that address lands on the clock edge, so the old contents are what the
// caller sees while it overwrites them.
// Ports:
//   clk      system clock
//   wr_en    write strobe (one accepted pixel)
//   addr     column address
//   wr_data  data stored at addr on the edge
//   rd_data  current contents at addr
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wr_data;
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Turns a raster pixel stream into interior 3x3 neighbourhoods for the
// sharpening kernel. Two chained line buffers hold rows r-1 and r-2; a 3x3
// shift array collects columns; a window is registered for every accepted
// pixel with row>=2 and col>=2, with win_done one cycle after the accept.
// Build option: define WIN_FRAME_DONE_EN to add frame_done, a pulse
// coincident with the final window of a completed frame.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   pix_in/_valid/_sof     raster pixel, qualifier, start of frame
//   win_0..win_8           window taps, row-major (win_4 = centre)
//   win_done               one-cycle window strobe
//   frame_done             (WIN_FRAME_DONE_EN only) last-window strobe
//
// state    | meaning
// S_IDLE   | waiting for sof; non-sof pixels dropped
// S_FILL   | rows 0..1 being loaded into the line buffers
// S_ACTIVE | rows 2..IMG_H-1, windows emitted at col>=2
module window_3x3_gen
  import sharpen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_in_valid,
  input  logic             pix_in_sof,
  output logic [WIDTH-1:0] win_0,
  output logic [WIDTH-1:0] win_1,
  output logic [WIDTH-1:0] win_2,
  output logic [WIDTH-1:0] win_3,
  output logic [WIDTH-1:0] win_4,
  output logic [WIDTH-1:0] win_5,
  output logic [WIDTH-1:0] win_6,
  output logic [WIDTH-1:0] win_7,
  output logic [WIDTH-1:0] win_8,
`ifdef WIN_FRAME_DONE_EN
  output logic             frame_done,
`endif
  output logic             win_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  win_state_t       state_q, state_d;
  logic [CW-1:0]    col_q, col_d, pos_col;
  logic [RW-1:0]    row_q, row_d, pos_row;
  logic             is_sof, accept, emit, last_pix;
  logic [WIDTH-1:0] lb1_rd, lb2_rd;
  logic [WIDTH-1:0] sh_q [3][3];
  logic [WIDTH-1:0] sh_d [3][3];
  logic [WIDTH-1:0] win_q [WIN_TAPS];
  logic             done_q;

  // An sof pixel is always (0,0), whatever the counters say.
  always_comb begin
    is_sof   = pix_in_valid && pix_in_sof;
    accept   = pix_in_valid && ((state_q != S_IDLE) || pix_in_sof);
    pos_col  = is_sof ? '0 : col_q;
    pos_row  = is_sof ? '0 : row_q;
    last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    emit     = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      if (is_sof) begin
        state_d = S_FILL;
      end else begin
        case (state_q)
          S_FILL:   if (pos_row == RW'(2) && pos_col == '0) state_d = S_ACTIVE;
          S_ACTIVE: if (last_pix) state_d = S_IDLE;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (pos_col),
    .wr_data (pix_in),
    .rd_data (lb1_rd)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (pos_col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // Not cleared at line start: columns 0..1 of a line never emit, so the
  // previous line's leftovers are shifted out before they can be used.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sh_d[i][j] = sh_q[i][j];
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        sh_d[i][0] = sh_q[i][1];
        sh_d[i][1] = sh_q[i][2];
      end
      sh_d[0][2] = lb2_rd;
      sh_d[1][2] = lb1_rd;
      sh_d[2][2] = pix_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sh_q[i][j] <= sh_d[i][j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) win_q[k] <= '0;
    end else begin
      done_q <= emit;
      if (emit) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            win_q[i*3 + j] <= sh_d[i][j];
      end
    end
  end

`ifdef WIN_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) frame_done_q <= 1'b0;
    else       frame_done_q <= emit && last_pix;
  end

  assign frame_done = frame_done_q;
`endif

  assign win_0    = win_q[TAP_TL];
  assign win_1    = win_q[TAP_TC];
  assign win_2    = win_q[TAP_TR];
  assign win_3    = win_q[TAP_ML];
  assign win_4    = win_q[TAP_CENTRE];
  assign win_5    = win_q[TAP_MR];
  assign win_6    = win_q[TAP_BL];
  assign win_7    = win_q[TAP_BC];
  assign win_8    = win_q[TAP_BR];
  assign win_done = done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  typedef logic [9*WIDTH-1:0] win_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] pix_in;
  logic             pix_in_valid;
  logic             pix_in_sof;
  logic [WIDTH-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic             win_done;
`ifdef WIN_FRAME_DONE_EN
  logic             frame_done;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] img [2][IMG_H][IMG_W];
  win_t obs_q[$];
  int   obs_tag_q[$];
  win_t exp_q[$];
  int   exp_tag_q[$];
  int   idle_done;
  int   cur_tag;
  int   fd_cnt;
  int   fd_at;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_sof   (pix_in_sof),
    .win_0        (win_0),
    .win_1        (win_1),
    .win_2        (win_2),
    .win_3        (win_3),
    .win_4        (win_4),
    .win_5        (win_5),
    .win_6        (win_6),
    .win_7        (win_7),
    .win_8        (win_8),
`ifdef WIN_FRAME_DONE_EN
    .frame_done   (frame_done),
`endif
    .win_done     (win_done)
  );

  function automatic win_t pack_out();
    return {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
  endfunction

  // Reference: the window centred one row/col above-left of (r,c), taken
  // straight from the stored image.
  function automatic win_t model_win(int f, int r, int c);
    win_t w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[8*WIDTH-1:0], img[f][r-2+i][c-2+j]};
    return w;
  endfunction

  task automatic add_expected(input int f, input int npix);
    for (int k = 0; k < npix; k++) begin
      if ((k / IMG_W) >= 2 && (k % IMG_W) >= 2) begin
        exp_q.push_back(model_win(f, k / IMG_W, k % IMG_W));
        exp_tag_q.push_back(f * 1000 + k);
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_tag_q.delete();
    exp_q.delete();
    exp_tag_q.delete();
    idle_done = 0;
    fd_cnt    = 0;
    fd_at     = -1;
  endtask

  task automatic fill_ramp(input int f);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[f][r][c] = WIDTH'((r << 4) | c);
  endtask

  task automatic fill_rand(input int f);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[f][r][c] = WIDTH'($urandom_range(255, 0));
  endtask

  // One clock of stimulus, then record whatever the DUT produced for it.
  task automatic send_cycle(input logic [WIDTH-1:0] p, input logic v, input logic s);
    pix_in       = p;
    pix_in_valid = v;
    pix_in_sof   = s;
    @(posedge clk);
    #1;
    if (win_done === 1'b1) begin
      obs_q.push_back(pack_out());
      obs_tag_q.push_back(v ? cur_tag : -1);
      if (!v) idle_done++;
    end
`ifdef WIN_FRAME_DONE_EN
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_at = (win_done === 1'b1) ? obs_q.size() : -1;
    end
`endif
  endtask

  task automatic send_frame(input int f, input int npix, input int gap_max);
    for (int k = 0; k < npix; k++) begin
      cur_tag = f * 1000 + k;
      send_cycle(img[f][k / IMG_W][k % IMG_W], 1'b1, k == 0);
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max, 0);
        for (int i = 0; i < g; i++)
          send_cycle(WIDTH'($urandom_range(255, 0)), 1'b0, 1'($urandom_range(1, 0)));
      end
    end
    pix_in_valid = 1'b0;
    pix_in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    pix_in       = '0;
    pix_in_valid = 1'b0;
    pix_in_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (win_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b expected 0", win_done);
    end
    n_cmp++;
    if (pack_out() !== '0) begin
      n_bad++;
      $display("FAIL reset_win: got %h expected 0", pack_out());
    end
`ifdef WIN_FRAME_DONE_EN
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_frame_done: got %b expected 0", frame_done);
    end
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    win_t last_ref;
    last_ref = {8'h35, 8'h36, 8'h37, 8'h45, 8'h46, 8'h47, 8'h55, 8'h56, 8'h57};
    clear_obs();
    fill_ramp(0);
    add_expected(0, NPIX);
    send_frame(0, NPIX, 0);
    repeat (3) send_cycle('0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== NWIN) begin
      n_bad++;
      $display("FAIL ramp_count: got %0d expected %0d", obs_q.size(), NWIN);
    end
    n_cmp++;
    if (obs_tag_q.size() == 0 || obs_tag_q[0] !== 2 * IMG_W + 2) begin
      n_bad++;
      $display("FAIL ramp_first_latency: got tag %0d expected %0d",
               (obs_tag_q.size() > 0) ? obs_tag_q[0] : -1, 2 * IMG_W + 2);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_tag_q[i] !== exp_tag_q[i]) begin
        n_bad++;
        $display("FAIL ramp_win[%0d]: got %h tag %0d expected %h tag %0d",
                 i, obs_q[i], obs_tag_q[i], exp_q[i], exp_tag_q[i]);
      end
    end
    n_cmp++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== last_ref) begin
      n_bad++;
      $display("FAIL ramp_last_win: got %h expected %h",
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : '0, last_ref);
    end
    n_cmp++;
    if (pack_out() !== last_ref) begin
      n_bad++;
      $display("FAIL ramp_hold: got %h expected %h", pack_out(), last_ref);
    end
`ifdef WIN_FRAME_DONE_EN
    n_cmp++;
    if (fd_cnt !== 1 || fd_at !== NWIN) begin
      n_bad++;
      $display("FAIL ramp_frame_done: got %0d pulses at window %0d expected 1 at %0d",
               fd_cnt, fd_at, NWIN);
    end
`endif
  endtask

  task automatic test_gaps();
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      if (pass == 0) fill_ramp(0);
      else           fill_rand(0);
      add_expected(0, NPIX);
      send_frame(0, NPIX, 5);
      repeat (2) send_cycle('0, 1'b0, 1'b0);
      n_cmp++;
      if (idle_done !== 0) begin
        n_bad++;
        $display("FAIL gaps_idle_done[%0d]: got %0d expected 0", pass, idle_done);
      end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
        n_bad++;
        $display("FAIL gaps_count[%0d]: got %0d expected %0d", pass, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i] || obs_tag_q[i] !== exp_tag_q[i]) begin
          n_bad++;
          $display("FAIL gaps_win[%0d][%0d]: got %h tag %0d expected %h tag %0d",
                   pass, i, obs_q[i], obs_tag_q[i], exp_q[i], exp_tag_q[i]);
        end
      end
`ifdef WIN_FRAME_DONE_EN
      n_cmp++;
      if (fd_cnt !== 1 || fd_at !== NWIN) begin
        n_bad++;
        $display("FAIL gaps_frame_done[%0d]: got %0d pulses at %0d expected 1 at %0d",
                 pass, fd_cnt, fd_at, NWIN);
      end
`endif
    end
  endtask

  task automatic test_presof();
    clear_obs();
    cur_tag = -1;
    for (int i = 0; i < 10; i++)
      send_cycle(WIDTH'($urandom_range(255, 0)), 1'b1, 1'b0);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL presof_dropped: got %0d windows expected 0", obs_q.size());
    end
    fill_ramp(0);
    add_expected(0, NPIX);
    send_frame(0, NPIX, 0);
    repeat (2) send_cycle('0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL presof_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_tag_q[i] !== exp_tag_q[i]) begin
        n_bad++;
        $display("FAIL presof_win[%0d]: got %h tag %0d expected %h tag %0d",
                 i, obs_q[i], obs_tag_q[i], exp_q[i], exp_tag_q[i]);
      end
    end
  endtask

  task automatic test_sof_restart();
    int cut;
    cut = 3 * IMG_W + 4;
    clear_obs();
    fill_rand(0);
    fill_rand(1);
    add_expected(0, cut);
    add_expected(1, NPIX);
    send_frame(0, cut, 2);
    send_frame(1, NPIX, 2);
    repeat (2) send_cycle('0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL restart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_tag_q[i] !== exp_tag_q[i]) begin
        n_bad++;
        $display("FAIL restart_win[%0d]: got %h tag %0d expected %h tag %0d",
                 i, obs_q[i], obs_tag_q[i], exp_q[i], exp_tag_q[i]);
      end
    end
`ifdef WIN_FRAME_DONE_EN
    n_cmp++;
    if (fd_cnt !== 1 || fd_at !== exp_q.size()) begin
      n_bad++;
      $display("FAIL restart_frame_done: got %0d pulses at %0d expected 1 at %0d",
               fd_cnt, fd_at, exp_q.size());
    end
`endif
  endtask

  task automatic test_reset_mid();
    int cut;
    cut = 4 * IMG_W + 3;
    clear_obs();
    fill_rand(0);
    fill_rand(1);
    add_expected(0, cut);
    add_expected(1, NPIX);
    send_frame(0, cut, 0);
    cur_tag = -1;
    reset = 1'b1;
    send_cycle(img[0][4][3], 1'b1, 1'b0);
    reset = 1'b0;
    n_cmp++;
    if (win_done !== 1'b0) begin
      n_bad++;
      $display("FAIL resetmid_done: got %b expected 0", win_done);
    end
    n_cmp++;
    if (pack_out() !== '0) begin
      n_bad++;
      $display("FAIL resetmid_win: got %h expected 0", pack_out());
    end
    for (int i = 0; i < 5; i++)
      send_cycle(WIDTH'($urandom_range(255, 0)), 1'b1, 1'b0);
    n_cmp++;
    if (obs_q.size() !== cut / IMG_W * 0 + 13) begin
      n_bad++;
      $display("FAIL resetmid_no_output: got %0d windows expected 13", obs_q.size());
    end
    send_frame(1, NPIX, 1);
    repeat (2) send_cycle('0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL resetmid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_tag_q[i] !== exp_tag_q[i]) begin
        n_bad++;
        $display("FAIL resetmid_win[%0d]: got %h tag %0d expected %h tag %0d",
                 i, obs_q[i], obs_tag_q[i], exp_q[i], exp_tag_q[i]);
      end
    end
`ifdef WIN_FRAME_DONE_EN
    n_cmp++;
    if (fd_cnt !== 1 || fd_at !== exp_q.size()) begin
      n_bad++;
      $display("FAIL resetmid_frame_done: got %0d pulses at %0d expected 1 at %0d",
               fd_cnt, fd_at, exp_q.size());
    end
`endif
  endtask

  initial begin
    reset        = 1'b1;
    pix_in       = '0;
    pix_in_valid = 1'b0;
    pix_in_sof   = 1'b0;
    cur_tag      = -1;
    clear_obs();
    test_reset();
    test_ramp();
    test_gaps();
    test_presof();
    test_sof_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
